// File: rtl/dds_wavegen.sv
// rtl/dds_wavegen.sv - DDS waveform generator: phase accumulator, 4-stage sample pipeline, buffered params
module dds_wavegen #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 10,
  parameter int AMP_W   = 8
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic               TICK,
  input  logic               CLR,
  input  logic               LOAD,
  input  logic [PHASE_W-1:0] FREQ,
  input  logic [PHASE_W-1:0] PHOFF,
  input  logic [1:0]         MODE,
  input  logic [AMP_W-1:0]   AMP,
  output logic [ADDR_W-1:0]  ROM_ADDR,
  input  logic [DATA_W-1:0]  ROM_DATA,
  output logic [DATA_W-1:0]  DOUT,
  output logic               DOUT_VALID,
  output logic               LOAD_PEND
);

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  // Pending (shadow) and active parameter sets
  logic [PHASE_W-1:0] freq_pend_q, phoff_pend_q;
  mode_e              mode_pend_q;
  logic [AMP_W-1:0]   amp_pend_q;
  logic               load_pend_q;

  logic [PHASE_W-1:0] freq_act_q, phoff_act_q;
  mode_e              mode_act_q;
  logic [AMP_W-1:0]   amp_act_q;

  // Phase accumulator
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ph_d;
  logic               launch;

  // Stage 1: captured phase slice, mode, amplitude
  logic               s1_vld_q;
  logic [DATA_W-1:0]  s1_p_q;
  mode_e              s1_mode_q;
  logic [AMP_W-1:0]   s1_amp_q;
  logic [ADDR_W-1:0]  rom_addr_q;

  // Stage 2: ROM access cycle, phase slice carried alongside
  logic               s2_vld_q;
  logic [DATA_W-1:0]  s2_p_q;
  mode_e              s2_mode_q;
  logic [AMP_W-1:0]   s2_amp_q;

  // Stage 3: raw unscaled sample
  logic               s3_vld_q;
  logic [DATA_W-1:0]  s3_raw_q, raw_d;
  logic [AMP_W-1:0]   s3_amp_q;

  // Stage 4: scaled output
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_vld_q;
  logic [AMP_W:0]      amp_p1;
  logic [DATA_W+AMP_W:0] prod;

  logic unused_ph;
  logic unused_prod;

  assign launch = TICK & ~CLR;
  assign ph_d   = acc_q + phoff_act_q;

  // Next accumulator value: clear has priority over the tick increment
  always_comb begin
    acc_d = acc_q;
    if (CLR) begin
      acc_d = '0;
    end else if (TICK) begin
      acc_d = acc_q + freq_act_q;
    end
  end

  // LOAD captures into pending; the first later TICK moves pending into active
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      freq_pend_q  <= '0;
      phoff_pend_q <= '0;
      mode_pend_q  <= MODE_SINE;
      amp_pend_q   <= '0;
      load_pend_q  <= 1'b0;
      freq_act_q   <= '0;
      phoff_act_q  <= '0;
      mode_act_q   <= MODE_SINE;
      amp_act_q    <= '0;
    end else if (LOAD) begin
      freq_pend_q  <= FREQ;
      phoff_pend_q <= PHOFF;
      mode_pend_q  <= mode_e'(MODE);
      amp_pend_q   <= AMP;
      load_pend_q  <= 1'b1;
    end else if (TICK && load_pend_q) begin
      freq_act_q   <= freq_pend_q;
      phoff_act_q  <= phoff_pend_q;
      mode_act_q   <= mode_pend_q;
      amp_act_q    <= amp_pend_q;
      load_pend_q  <= 1'b0;
    end
  end

  // Accumulator register
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Stage 1: latch pre-increment phase plus offset, drive the ROM address
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld_q   <= 1'b0;
      s1_p_q     <= '0;
      s1_mode_q  <= MODE_SINE;
      s1_amp_q   <= '0;
      rom_addr_q <= '0;
    end else begin
      s1_vld_q <= launch;
      if (launch) begin
        s1_p_q     <= ph_d[PHASE_W-1 -: DATA_W];
        s1_mode_q  <= mode_act_q;
        s1_amp_q   <= amp_act_q;
        rom_addr_q <= ph_d[PHASE_W-1 -: ADDR_W];
      end
    end
  end

  // Stage 2: wait for the synchronous ROM while carrying the sample context
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      s2_vld_q  <= 1'b0;
      s2_p_q    <= '0;
      s2_mode_q <= MODE_SINE;
      s2_amp_q  <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_p_q    <= s1_p_q;
        s2_mode_q <= s1_mode_q;
        s2_amp_q  <= s1_amp_q;
      end
    end
  end

  // Waveform shape selection from the phase slice or ROM data
  always_comb begin
    raw_d = '0;
    unique case (s2_mode_q)
      MODE_SINE: raw_d = ROM_DATA;
      MODE_SAW:  raw_d = s2_p_q;
      MODE_TRI:  begin
        if (s2_p_q[DATA_W-1]) raw_d = ~{s2_p_q[DATA_W-2:0], 1'b0};
        else                  raw_d =  {s2_p_q[DATA_W-2:0], 1'b0};
      end
      MODE_SQR:  raw_d = {DATA_W{~s2_p_q[DATA_W-1]}};
      default:   raw_d = '0;
    endcase
  end

  // Stage 3: register the raw sample
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      s3_vld_q <= 1'b0;
      s3_raw_q <= '0;
      s3_amp_q <= '0;
    end else begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_raw_q <= raw_d;
        s3_amp_q <= s2_amp_q;
      end
    end
  end

  // Gain (AMP+1)/2^AMP_W; the product never exceeds raw, so the top bit stays zero
  always_comb begin
    amp_p1 = {1'b0, s3_amp_q} + {{AMP_W{1'b0}}, 1'b1};
    prod   = {{(AMP_W+1){1'b0}}, s3_raw_q} * {{DATA_W{1'b0}}, amp_p1};
    dout_d = prod[AMP_W +: DATA_W];
  end

  // Stage 4: output register, held between samples, with a one-cycle valid pulse
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= s3_vld_q;
      if (s3_vld_q) begin
        dout_q <= dout_d;
      end
    end
  end

  assign unused_ph   = ^ph_d;
  assign unused_prod = ^prod;

  assign ROM_ADDR   = rom_addr_q;
  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_vld_q;
  assign LOAD_PEND  = load_pend_q;

endmodule
